// File: rtl/Pipe_Buf_Reg_PKG.sv
// Shared types for pipeline buffer registers: stage occupancy state and
// the packed payload carried between stages.
package Pipe_Buf_Reg_PKG;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_e;

    // Default stage payload; its width matches the stage's default WIDTH
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } stage_payload_t;

    localparam int PAYLOAD_W = $bits(stage_payload_t);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter that adds 0, 1 or 2 per cycle and sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W:0] MAX = {1'b0, {CNT_W{1'b1}}};

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        if (sum > MAX)
            sum = MAX;
        return sum[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else
            count <= sat_add(count, inc);
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry pipeline register with skid buffer: registered in_ready, stall
// bubbles, flush with a saturating discard count.
module pipe_skid_stage
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int               WIDTH  = 64,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             stall,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] flush_cnt
);

    occ_state_e       st_q, st_d;
    logic [WIDTH-1:0] main_data, skid_data;
    logic             accept, deq;
    logic             main_ld_in, main_ld_skid, skid_ld;
    logic [1:0]       discard;

    // Ready and valid depend only on registered state and stall
    assign in_ready  = (st_q != ST_FULL) && !stall;
    assign out_valid = (st_q != ST_EMPTY) && !stall;
    assign out_data  = out_valid ? main_data : BUBBLE;
    assign occupancy = st_q;

    assign accept = in_valid && in_ready && !flush;
    assign deq    = out_valid && out_ready && !flush;

    always_comb begin
        st_d         = st_q;
        main_ld_in   = 1'b0;
        main_ld_skid = 1'b0;
        skid_ld      = 1'b0;
        discard      = 2'd0;
        if (flush) begin
            st_d    = ST_EMPTY;
            discard = (st_q == ST_FULL) ? 2'd2 : (st_q == ST_ONE) ? 2'd1 : 2'd0;
        end else begin
            case (st_q)
                ST_EMPTY: begin
                    if (accept) begin
                        st_d       = ST_ONE;
                        main_ld_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && deq) begin
                        main_ld_in = 1'b1;
                    end else if (accept) begin
                        st_d    = ST_FULL;
                        skid_ld = 1'b1;
                    end else if (deq) begin
                        st_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (deq) begin
                        st_d         = ST_ONE;
                        main_ld_skid = 1'b1;
                    end
                end
                default: st_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            st_q <= ST_EMPTY;
        else
            st_q <= st_d;
    end

    // Payload registers carry no reset; their contents are qualified by st_q
    always_ff @(posedge clk) begin
        if (main_ld_in)
            main_data <= in_data;
        else if (main_ld_skid)
            main_data <= skid_data;
        if (skid_ld)
            skid_data <= in_data;
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (discard),
        .count(flush_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed vector table, streaming and reset
// sequences, then random traffic against a queue-based reference model.
module tb_pipe_skid_stage;

    localparam int               W   = 16;
    localparam int               CW  = 2;
    localparam logic [W-1:0]     BUB = 16'hBEEF;
    localparam int               CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready, out_valid, out_ready, stall, flush;
    logic [W-1:0]  in_data, out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] flush_cnt;

    always #5 clk = ~clk;

    pipe_skid_stage #(.WIDTH(W), .BUBBLE(BUB), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .stall(stall), .flush(flush),
        .occupancy(occupancy), .flush_cnt(flush_cnt)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          iv;
        logic [W-1:0]  d;
        logic          ordy;
        logic          st;
        logic          fl;
        logic          ov;
        logic [W-1:0]  od;
        logic          ir;
        logic [1:0]    occ;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t tbl[29];

    logic [W-1:0] mq[$];
    int           mcnt;

    function automatic vec_t mk(int iv, int d, int ordy, int st, int fl,
                                int ov, int od, int ir, int occ, int cnt);
        vec_t v;
        v.iv = iv[0]; v.d = d[W-1:0]; v.ordy = ordy[0]; v.st = st[0]; v.fl = fl[0];
        v.ov = ov[0]; v.od = od[W-1:0]; v.ir = ir[0]; v.occ = occ[1:0]; v.cnt = cnt[CW-1:0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic ov, input logic [W-1:0] od,
                           input logic ir, input logic [1:0] occ, input logic [CW-1:0] cnt);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".out_data"},  32'(out_data),  32'(od));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
        chk({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
        chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(cnt));
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy,
                         input logic st, input logic fl);
        in_valid = iv; in_data = d; out_ready = ordy; stall = st; flush = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, '0, 0, 0, 0);
        reset = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk_all("reset_state", 1'b0, BUB, 1'b1, 2'd0, '0);
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, '0, 0, 0, 0);
        #1;

        // Directed table: inputs for the cycle and outputs expected during it
        tbl[0]  = mk(1, 'h11, 1, 0, 0,  0, BUB,  1, 0, 0);
        tbl[1]  = mk(0, 0,    1, 0, 0,  1, 'h11, 1, 1, 0);
        tbl[2]  = mk(0, 0,    1, 0, 0,  0, BUB,  1, 0, 0);
        tbl[3]  = mk(1, 'hA1, 0, 0, 0,  0, BUB,  1, 0, 0);
        tbl[4]  = mk(1, 'hA2, 0, 0, 0,  1, 'hA1, 1, 1, 0);
        tbl[5]  = mk(0, 0,    0, 0, 0,  1, 'hA1, 0, 2, 0);
        tbl[6]  = mk(0, 0,    1, 0, 0,  1, 'hA1, 0, 2, 0);
        tbl[7]  = mk(0, 0,    1, 0, 0,  1, 'hA2, 1, 1, 0);
        tbl[8]  = mk(0, 0,    1, 0, 0,  0, BUB,  1, 0, 0);
        tbl[9]  = mk(1, 'h5A, 0, 0, 0,  0, BUB,  1, 0, 0);
        tbl[10] = mk(0, 0,    1, 1, 0,  0, BUB,  0, 1, 0);
        tbl[11] = mk(1, 'h77, 1, 1, 0,  0, BUB,  0, 1, 0);
        tbl[12] = mk(0, 0,    1, 1, 0,  0, BUB,  0, 1, 0);
        tbl[13] = mk(0, 0,    1, 0, 0,  1, 'h5A, 1, 1, 0);
        tbl[14] = mk(0, 0,    1, 0, 0,  0, BUB,  1, 0, 0);
        tbl[15] = mk(1, 'hB1, 0, 0, 0,  0, BUB,  1, 0, 0);
        tbl[16] = mk(1, 'hB2, 0, 0, 0,  1, 'hB1, 1, 1, 0);
        tbl[17] = mk(1, 'hC3, 0, 0, 1,  1, 'hB1, 0, 2, 0);
        tbl[18] = mk(0, 0,    1, 0, 0,  0, BUB,  1, 0, 2);
        tbl[19] = mk(1, 'hD1, 0, 0, 0,  0, BUB,  1, 0, 2);
        tbl[20] = mk(1, 'hD2, 0, 0, 0,  1, 'hD1, 1, 1, 2);
        tbl[21] = mk(0, 0,    1, 0, 1,  1, 'hD1, 0, 2, 2);
        tbl[22] = mk(0, 0,    1, 0, 0,  0, BUB,  1, 0, 3);
        tbl[23] = mk(1, 'hE1, 0, 0, 0,  0, BUB,  1, 0, 3);
        tbl[24] = mk(1, 'hE2, 1, 0, 1,  1, 'hE1, 1, 1, 3);
        tbl[25] = mk(0, 0,    1, 0, 0,  0, BUB,  1, 0, 3);
        tbl[26] = mk(1, 'hF1, 0, 0, 0,  0, BUB,  1, 0, 3);
        tbl[27] = mk(1, 'hF2, 1, 1, 1,  0, BUB,  0, 1, 3);
        tbl[28] = mk(0, 0,    1, 0, 0,  0, BUB,  1, 0, 3);

        do_reset();
        for (int i = 0; i < 29; i++) begin
            drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].st, tbl[i].fl);
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), tbl[i].ov, tbl[i].od, tbl[i].ir,
                    tbl[i].occ, tbl[i].cnt);
            next_cycle();
        end

        // Saturated count must clear on reset
        do_reset();

        // Back-to-back stream: one transfer per cycle, one cycle of latency
        for (int i = 0; i <= 16; i++) begin
            drive(i < 16, W'(i + 1), 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            chk($sformatf("stream%0d.in_ready", i), 32'(in_ready), 32'd1);
            chk($sformatf("stream%0d.out_valid", i), 32'(out_valid), 32'(i > 0));
            chk($sformatf("stream%0d.out_data", i), 32'(out_data), (i > 0) ? 32'(i) : 32'(BUB));
            next_cycle();
        end

        // Reset beats a simultaneous flush: held entries are not counted
        drive(1, 16'h0042, 0, 0, 0);
        next_cycle();
        drive(1, 16'h0043, 0, 0, 1);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        drive(0, '0, 1, 0, 0);
        @(negedge clk);
        chk_all("reset_over_flush", 1'b0, BUB, 1'b1, 2'd0, '0);
        next_cycle();

        // Random traffic against the queue model
        do_reset();
        mq.delete();
        mcnt = 0;
        for (int c = 0; c < 3000; c++) begin
            logic           r_rst, r_iv, r_or, r_st, r_fl;
            logic           e_ov, e_ir;
            logic [W-1:0]   e_od;
            r_rst = ($urandom_range(0, 199) == 0);
            r_iv  = ($urandom_range(0, 9) < 7);
            r_or  = ($urandom_range(0, 9) < 6);
            r_st  = ($urandom_range(0, 9) == 0);
            r_fl  = ($urandom_range(0, 19) == 0);
            drive(r_iv, W'($urandom), r_or, r_st, r_fl);
            reset = r_rst;
            e_ov = (mq.size() > 0) && !r_st;
            e_od = e_ov ? mq[0] : BUB;
            e_ir = (mq.size() < 2) && !r_st;
            @(negedge clk);
            chk_all($sformatf("rand%0d", c), e_ov, e_od, e_ir, 2'(mq.size()), CW'(mcnt));
            if (r_rst) begin
                mq.delete();
                mcnt = 0;
            end else if (r_fl) begin
                mcnt = (mcnt + mq.size() > CMAX) ? CMAX : mcnt + mq.size();
                mq.delete();
            end else begin
                if (e_ov && r_or)
                    void'(mq.pop_front());
                if (e_ir && r_iv)
                    mq.push_back(in_data);
            end
            next_cycle();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter WIDTH, default 64, payload width in bits; packed stage structs are passed as this width.
REQ-002 Parameter BUBBLE, default all-zero WIDTH-bit value, payload driven on out_data whenever out_valid is 0.
REQ-003 Parameter CNT_W, default 8, width of the flush-discard counter.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream offers in_data this cycle.
REQ-007 in_ready  output  1  stage can accept this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  stage presents valid payload.
REQ-010 out_ready  input  1  downstream accepts this cycle.
REQ-011 out_data  output  WIDTH  payload to downstream.
REQ-012 stall  input  1  hazard hold: freezes transfers and emits a bubble downstream.
REQ-013 flush  input  1  kill all held entries (branch/jump redirect).
REQ-014 occupancy  output  2  entries held: 0, 1 or 2.
REQ-015 flush_cnt  output  CNT_W  saturating count of valid entries discarded by flush.

Function
REQ-016 Storage: two entries, main and skid; states EMPTY (none), ONE (main valid), FULL (main and skid valid).
REQ-017 in_ready = (state != FULL) and not stall; the FULL term comes from a register, with no combinational path from out_ready.
REQ-018 out_valid = (state != EMPTY) and not stall; out_data = main payload when out_valid is 1, else BUBBLE.
REQ-019 accept = in_valid and in_ready and not flush; deq = out_valid and out_ready and not flush.
REQ-020 EMPTY: accept -> ONE, main <= in_data.
REQ-021 ONE: accept and deq -> ONE, main <= in_data; accept only -> FULL, skid <= in_data; deq only -> EMPTY; neither -> hold.
REQ-022 FULL: deq -> ONE, main <= skid; otherwise hold; no accept is possible.
REQ-023 Latency: in_data accepted in cycle N appears on out_data with out_valid in cycle N+1 when the stage was EMPTY; sustained throughput is 1 transfer per cycle with out_ready held high.
REQ-024 Ordering: payloads leave in acceptance order; no payload is duplicated or lost except by flush.
REQ-025 flush: next state EMPTY regardless of in_valid, out_ready and stall; flush has priority over stall; no transfer is counted in a flush cycle.
REQ-026 flush_cnt increments by the number of valid entries held in the flush cycle (0, 1 or 2) and saturates at 2^CNT_W-1 without wrap.
REQ-027 stall with no flush: state, main, skid and flush_cnt hold; in_valid is ignored.
REQ-028 occupancy = 0/1/2 for EMPTY/ONE/FULL, registered.

Reset
REQ-029 reset -> state EMPTY, occupancy 0, flush_cnt 0, out_valid 0, out_data BUBBLE, in_ready 1 (if stall is 0); main/skid payload contents are don't-care.
REQ-030 reset asserted mid-transfer discards all held entries without counting them in flush_cnt; reset has priority over flush and stall.

Structure
REQ-031 The stage-occupancy state enum (EMPTY/ONE/FULL) shall be defined in the shared package Pipe_Buf_Reg_PKG alongside the stage payload structs.
REQ-032 The saturating discard counter shall be a sub-module named sat_counter (parameters CNT_W, max increment 2); everything else stays in pipe_skid_stage.

Verification
REQ-033 Reset, then in_valid=1 with in_data=0x11 for one cycle and out_ready=1 -> out_valid=1 and out_data=0x11 in the next cycle only, then out_data=BUBBLE.
REQ-034 out_ready=0; push 0xA1 and 0xA2 -> occupancy 2, in_ready=0; raise out_ready -> 0xA1 then 0xA2 on consecutive cycles, occupancy back to 0.
REQ-035 Stream 0x01..0x10 with out_ready=1 -> 16 outputs on 16 consecutive cycles, in order, in_ready never 0.
REQ-036 FULL, then flush=1 together with in_valid=1 -> next cycle occupancy 0, out_valid=0, flush_cnt +2, incoming payload absent from output.
REQ-037 ONE holding 0x5A, stall=1 for 3 cycles -> out_valid=0, out_data=BUBBLE, occupancy 1; release -> 0x5A delivered exactly once.
REQ-038 CNT_W=2, flush FULL twice -> flush_cnt 2 then 3 (saturated); reset -> flush_cnt 0.
